if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC, drives the combinational instruction ROM address, and registers the returned word into the IF/ID pipeline register.
- Applies redirects (EX branch/jr, ID jump), exception and interrupt vectoring, stall and flush.
- PC[31] is the kernel/supervisor bit; the ROM sees only PC[30:0].

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/if_next_pc.sv | 36 +++
 rtl/if_stage.sv | 58 +++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: reset/vector addresses, bubble word, IF control bundle.
package cpu_pkg;
    localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BUBBLE = 2'd2,
        SEL_IRQ    = 2'd3
    } if_sel_e;

    typedef struct packed {
        logic        ex_redirect;
        logic [31:0] ex_target;
        logic        exc_req;
        logic        stall;
        logic        id_jump;
        logic [31:0] id_jump_target;
        logic        irq;
    } if_ctl_t;

    // Sequential fetch advances the low 31 bits only; the kernel bit is sticky.
    function automatic logic [31:0] pc_inc4(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction
endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection for the fetch stage, in redirect priority order.
module if_next_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc,
    input  if_ctl_t     ctl,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output if_sel_e     sel
);
    always_comb begin
        pc_plus4 = pc_inc4(pc);
        next_pc  = pc_plus4;
        sel      = SEL_SEQ;
        if (ctl.ex_redirect) begin
            next_pc = ctl.ex_target;
            sel     = SEL_BUBBLE;
        end else if (ctl.exc_req) begin
            next_pc = EXC_VECTOR;
            sel     = SEL_BUBBLE;
        end else if (ctl.stall) begin
            next_pc = pc;
            sel     = SEL_HOLD;
        end else if (ctl.id_jump) begin
            next_pc = ctl.id_jump_target;
            sel     = SEL_BUBBLE;
        end else if (ctl.irq && !pc[31]) begin
            // Kernel-mode fetch masks the interrupt; the level stays pending.
            next_pc = IRQ_VECTOR;
            sel     = SEL_IRQ;
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM address, and the IF/ID pipeline register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        exc_req,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        irq,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_irq
);
    if_ctl_t     ctl;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    if_sel_e     sel;

    assign ctl = '{ex_redirect: ex_redirect, ex_target: ex_target, exc_req: exc_req,
                   stall: stall, id_jump: id_jump, id_jump_target: id_jump_target, irq: irq};
    assign rom_addr = pc[30:0];

    if_next_pc #(.IRQ_VECTOR(IRQ_VECTOR), .EXC_VECTOR(EXC_VECTOR)) u_next (
        .pc       (pc),
        .ctl      (ctl),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc),
        .sel      (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            if_id_irq      <= 1'b0;
        end else if (sel != SEL_HOLD) begin
            pc             <= next_pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_instr    <= (sel == SEL_SEQ) ? rom_data : NOP_WORD;
            if_id_valid    <= (sel == SEL_SEQ);
            if_id_irq      <= (sel == SEL_IRQ);
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed + randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset, stall, ex_redirect, exc_req, id_jump, irq;
    logic [31:0] ex_target, id_jump_target, rom_data, pc;
    logic [30:0] rom_addr;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, if_id_irq;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_irq;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [30:0] a);
        return (32'h9E37_79B9 * {1'b0, a}) ^ 32'h0BAD_F00D;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .exc_req(exc_req), .id_jump(id_jump),
        .id_jump_target(id_jump_target), .irq(irq), .rom_addr(rom_addr),
        .rom_data(rom_data), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .if_id_irq(if_id_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; ex_redirect = 0; exc_req = 0; id_jump = 0; irq = 0;
        ex_target = '0; id_jump_target = '0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare everything.
    task automatic cyc();
        logic [31:0] seq;
        logic        bub, irqb;
        seq  = {m_pc[31], (m_pc[30:0] + 31'd4)};
        bub  = 1'b1;
        irqb = 1'b0;
        if (reset) begin
            m_pc = 32'h8000_0000; m_instr = 0; m_pp4 = 0; m_valid = 0; m_irq = 0;
            bub = 0;
        end else if (ex_redirect) m_pc = ex_target;
        else if (exc_req)         m_pc = 32'h8000_0008;
        else if (stall)           bub = 0;
        else if (id_jump)         m_pc = id_jump_target;
        else if (irq && m_pc[31] == 1'b0) begin m_pc = 32'h8000_0004; irqb = 1; end
        else begin
            m_instr = rom_fn(m_pc[30:0]); m_pp4 = seq; m_valid = 1; m_irq = 0;
            m_pc = seq; bub = 0;
        end
        if (bub) begin
            m_instr = 0; m_pp4 = seq; m_valid = 0; m_irq = irqb;
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("rom_addr", {1'b0, rom_addr}, {1'b0, m_pc[30:0]});
        chk("instr", if_id_instr, m_instr);
        chk("pc_plus4", if_id_pc_plus4, m_pp4);
        chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("irq_mark", {31'd0, if_id_irq}, {31'd0, m_irq});
    endtask

    initial begin
        m_pc = 'x; m_instr = 'x; m_pp4 = 'x; m_valid = 'x; m_irq = 'x;
        idle();
        reset = 1;
        cyc(); cyc();
        chk("reset_pc", pc, 32'h8000_0000);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_pp4", if_id_pc_plus4, 32'd0);
        reset = 0;
        cyc();
        chk("seq1_pc", pc, 32'h8000_0004);
        chk("seq1_instr", if_id_instr, rom_fn(31'h0));
        chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
        cyc();
        chk("seq2_pc", pc, 32'h8000_0008);
        cyc(); cyc();
        chk("at_10", pc, 32'h8000_0010);

        // Stall freeze, then redirect overriding stall
        stall = 1;
        repeat (3) cyc();
        chk("stall_pc", pc, 32'h8000_0010);
        chk("stall_instr", if_id_instr, rom_fn(31'h0C));
        ex_redirect = 1; ex_target = 32'h0000_0100;
        cyc();
        chk("redir_stall_pc", pc, 32'h0000_0100);
        chk("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);
        idle(); cyc();

        // EX redirect beats ID jump
        ex_redirect = 1; ex_target = 32'h8000_0200;
        id_jump = 1; id_jump_target = 32'h8000_004C;
        cyc();
        chk("ex_wins_pc", pc, 32'h8000_0200);
        idle(); cyc();
        id_jump = 1; id_jump_target = 32'h8000_004C;
        cyc();
        chk("jump_pc", pc, 32'h8000_004C);
        chk("jump_bubble", {31'd0, if_id_valid}, 32'd0);

        // Interrupt in user mode, masked in kernel, retaken after jr to user
        idle(); ex_redirect = 1; ex_target = 32'h0000_0040;
        cyc();
        idle(); irq = 1;
        cyc();
        chk("irq_pc", pc, 32'h8000_0004);
        chk("irq_mark1", {31'd0, if_id_irq}, 32'd1);
        chk("irq_pp4", if_id_pc_plus4, 32'h0000_0044);
        chk("irq_valid", {31'd0, if_id_valid}, 32'd0);
        repeat (3) cyc();
        chk("irq_masked_pc", pc, 32'h8000_0010);
        ex_redirect = 1; ex_target = 32'h0000_0040;
        cyc();
        chk("jr_user_pc", pc, 32'h0000_0040);
        ex_redirect = 0;
        cyc();
        chk("irq_retaken", pc, 32'h8000_0004);
        chk("irq_retaken_mark", {31'd0, if_id_irq}, 32'd1);

        // Exception beats stall
        idle(); ex_redirect = 1; ex_target = 32'h0000_0080;
        cyc();
        idle(); stall = 1; exc_req = 1;
        cyc();
        chk("exc_pc", pc, 32'h8000_0008);
        chk("exc_valid", {31'd0, if_id_valid}, 32'd0);

        // Low-31-bit wrap keeps kernel bit
        idle(); ex_redirect = 1; ex_target = 32'h7FFF_FFFC;
        cyc();
        idle(); cyc();
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_pp4", if_id_pc_plus4, 32'h0000_0000);
        ex_redirect = 1; ex_target = 32'hFFFF_FFFC;
        cyc();
        idle(); cyc();
        chk("wrap_kernel_pc", pc, 32'h8000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(63) == 0);
            stall          = ($urandom_range(3) == 0);
            ex_redirect    = ($urandom_range(7) == 0);
            exc_req        = ($urandom_range(15) == 0);
            id_jump        = ($urandom_range(7) == 0);
            irq            = ($urandom_range(2) == 0);
            ex_target      = {$urandom_range(1), 31'($urandom) & 31'h0000_FFFC};
            id_jump_target = {$urandom_range(1), 31'($urandom) & 31'h0000_FFFC};
            if (i % 50 == 49) begin
                idle(); ex_redirect = 1; ex_target = 32'h7FFF_FFF8;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
